// File: rtl/kmeans_regfile_v2.sv
`timescale 1ns/1ps
// Second-generation K-means register file: one-wait-state APB slave for the host,
// register/RAM-loader side-band toward the k-means core.
module kmeans_regfile_v2 #(
  parameter int DATA_W   = 91,
  parameter int ADDR_W   = 9,
  parameter int RAM_AW   = 9,
  parameter int NUM_CENT = 8,
  parameter int THR_W    = 16,
  parameter int REGN_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              irq,
  input  logic              core_done,
  input  logic [REGN_W-1:0] core_reg_num,
  input  logic              core_reg_write,
  input  logic [DATA_W-1:0] core_reg_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              go_core,
  output logic [RAM_AW-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_data_out,
  output logic              ram_we_n,
  output logic              ram_cs_n,
  output logic [RAM_AW-1:0] first_addr_out,
  output logic [RAM_AW-1:0] last_addr_out,
  output logic [THR_W-1:0]  threshold_out
);

  localparam logic [1:0] APB_IDLE   = 2'd0;
  localparam logic [1:0] APB_SETUP  = 2'd1;
  localparam logic [1:0] APB_ACCESS = 2'd2;

  localparam logic [1:0] RUN_IDLE = 2'd0;
  localparam logic [1:0] RUN_BUSY = 2'd1;
  localparam logic [1:0] RUN_DONE = 2'd2;

  localparam int MAP_N     = 32;
  localparam int CENT_BASE = 16;
  localparam logic [MAP_N-1:0] MAP_VALID =
      MAP_N'(32'h1FF) | (MAP_N'((64'd1 << NUM_CENT) - 64'd1) << CENT_BASE);

  logic [1:0]        apb_state_reg, apb_state_next;
  logic [1:0]        run_state_reg;
  logic              done_sticky_reg, err_sticky_reg;
  logic [RAM_AW-1:0] ram_addr_reg, first_reg, last_reg;
  logic [DATA_W-1:0] ram_data_reg;
  logic [THR_W-1:0]  thresh_reg;
  logic              auto_inc_reg, irq_en_reg;
  logic [15:0]       runs_reg;
  logic              strobe_reg;
  logic [DATA_W-1:0] cent_reg [NUM_CENT];
  logic [DATA_W-1:0] map_word [MAP_N];

  int unsigned apb_i, core_i;
  logic apb_mapped, core_mapped, status_w1c_ok, apb_err, access, commit, core_cent_wr;

  assign apb_i  = 32'(paddr);
  assign core_i = 32'(core_reg_num);
  assign apb_mapped  = (apb_i < MAP_N) && MAP_VALID[apb_i[4:0]];
  assign core_mapped = (core_i < MAP_N) && MAP_VALID[core_i[4:0]];

  // Only bit2 of STATUS is writable; any other set bit makes the write illegal.
  assign status_w1c_ok = ((pwdata & ~DATA_W'(4)) == '0);
  assign apb_err = !apb_mapped
                 || (pwrite && apb_i == 0 && !status_w1c_ok)
                 || (pwrite && apb_i == 8)
                 || (pwrite && run_state_reg == RUN_BUSY && apb_i != 0);

  assign access = (apb_state_reg == APB_ACCESS) && psel && penable;
  assign commit = access && pwrite && !apb_err;
  assign core_cent_wr = core_reg_write && (run_state_reg == RUN_BUSY)
                      && (core_i >= CENT_BASE) && (core_i < CENT_BASE + NUM_CENT);

  assign pready  = access;
  assign pslverr = access && apb_err;
  assign prdata  = (access && !apb_err && !pwrite) ? map_word[apb_i[4:0]] : '0;

  assign irq            = done_sticky_reg && irq_en_reg;
  assign go_core        = (run_state_reg == RUN_BUSY);
  assign ram_we_n       = !strobe_reg;
  assign ram_cs_n       = !strobe_reg;
  assign first_addr_out = first_reg;
  assign last_addr_out  = last_reg;
  assign threshold_out  = thresh_reg;

  always_comb begin
    apb_state_next = apb_state_reg;
    case (apb_state_reg)
      APB_IDLE:   if (psel && !penable) apb_state_next = APB_SETUP;
      APB_SETUP:  if (!psel) apb_state_next = APB_IDLE;
                  else if (penable) apb_state_next = APB_ACCESS;
      default:    apb_state_next = APB_IDLE;
    endcase
  end

  // Common read view shared by the APB and core ports; unmapped slots stay zero.
  always_comb begin
    for (int i = 0; i < MAP_N; i++) map_word[i] = '0;
    map_word[0] = DATA_W'({err_sticky_reg, done_sticky_reg, run_state_reg});
    map_word[2] = DATA_W'(ram_addr_reg);
    map_word[3] = ram_data_reg;
    map_word[4] = DATA_W'(first_reg);
    map_word[5] = DATA_W'(last_reg);
    map_word[6] = DATA_W'(thresh_reg);
    map_word[7] = DATA_W'({irq_en_reg, auto_inc_reg});
    map_word[8] = DATA_W'(runs_reg);
    for (int i = 0; i < NUM_CENT; i++) map_word[CENT_BASE + i] = cent_reg[i];
  end

  generate
    for (genvar gi = 0; gi < NUM_CENT; gi++) begin : g_cent
      logic [DATA_W-1:0] value_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          value_reg <= '0;
        end else if (commit && apb_i == 32'(CENT_BASE + gi)) begin
          value_reg <= pwdata;
        end else if (core_cent_wr && core_i == 32'(CENT_BASE + gi)) begin
          value_reg <= core_reg_wdata;
        end
      end
      assign cent_reg[gi] = value_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      apb_state_reg   <= APB_IDLE;
      run_state_reg   <= RUN_IDLE;
      done_sticky_reg <= 1'b0;
      err_sticky_reg  <= 1'b0;
      ram_addr_reg    <= '0;
      ram_data_reg    <= '0;
      first_reg       <= '0;
      last_reg        <= '0;
      thresh_reg      <= '0;
      auto_inc_reg    <= 1'b0;
      irq_en_reg      <= 1'b0;
      runs_reg        <= '0;
      strobe_reg      <= 1'b0;
      ram_addr_out    <= '0;
      ram_data_out    <= '0;
      core_rdata      <= '0;
    end else begin
      apb_state_reg <= apb_state_next;
      strobe_reg    <= 1'b0;
      core_rdata    <= core_mapped ? map_word[core_i[4:0]] : '0;
      if (strobe_reg && auto_inc_reg) ram_addr_reg <= ram_addr_reg + RAM_AW'(1);
      if (access && apb_err) err_sticky_reg <= 1'b1;
      if (commit) begin
        case (apb_i[4:0])
          5'd0: if (pwdata[2]) begin
                  done_sticky_reg <= 1'b0;
                  if (run_state_reg == RUN_DONE) run_state_reg <= RUN_IDLE;
                end
          5'd1: if (pwdata[0]) run_state_reg <= RUN_BUSY;
          5'd2: ram_addr_reg <= pwdata[RAM_AW-1:0];
          5'd3: begin
                  ram_data_reg <= pwdata;
                  ram_data_out <= pwdata;
                  ram_addr_out <= ram_addr_reg;
                  strobe_reg   <= 1'b1;
                end
          5'd4: first_reg  <= pwdata[RAM_AW-1:0];
          5'd5: last_reg   <= pwdata[RAM_AW-1:0];
          5'd6: thresh_reg <= pwdata[THR_W-1:0];
          5'd7: begin
                  auto_inc_reg <= pwdata[0];
                  irq_en_reg   <= pwdata[1];
                end
          default: ;
        endcase
      end
      // Run completion is evaluated last so a simultaneous W1C cannot lose it.
      if (core_done && run_state_reg == RUN_BUSY) begin
        run_state_reg   <= RUN_DONE;
        runs_reg        <= runs_reg + 16'd1;
        done_sticky_reg <= 1'b1;
      end
    end
  end

endmodule
